dp_byte_ram: RTL

Parametrised true-dual-port, byte-writable synchronous RAM. It succeeds the fixed 32-bit / 64K-word data memory. Port A serves the CPU MEM stage and port B serves the debug module. New features over the fixed memory:
- configurable width and depth
- port enables
- optional output register
- selectable same-port read-during-write mode
- deterministic cross-port write collision resolution with a counter
- post-reset zero-clear state machine

---
 rtl/dp_byte_ram.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dp_byte_ram.sv
// True-dual-port byte-writable synchronous RAM with optional output register,
// selectable same-port read-during-write, cross-port write arbitration and post-reset clear.
module dp_byte_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0,
  parameter int INIT_ZERO   = 1,
  localparam int LANES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic [LANES-1:0]      wea,
  input  logic [31:0]           addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  douta_vld,
  output logic                  addr_err_a,
  input  logic                  enb,
  input  logic [LANES-1:0]      web,
  input  logic [31:0]           addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_vld,
  output logic                  addr_err_b,
  output logic                  collision,
  output logic [15:0]           coll_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr;

  assign init_busy = (state_q == S_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= (INIT_ZERO != 0) ? S_CLEAR : S_READY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_ptr == {ADDR_WIDTH{1'b1}}) state_d = S_READY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         clr_ptr <= '0;
    else if (init_busy) clr_ptr <= clr_ptr + 1'b1;
  end

  // Port 0 is A, port 1 is B throughout.
  logic [1:0]                  en, acc, valid;
  logic [1:0][LANES-1:0]       we, own, wmask;
  logic [1:0][31:0]            addr;
  logic [1:0][DATA_WIDTH-1:0]  din;
  logic [1:0][ADDR_WIDTH-1:0]  idx;
  logic                        same, coll_now;

  assign en   = {enb, ena};
  assign we   = {web, wea};
  assign addr = {addrb, addra};
  assign din  = {dinb, dina};

  always_comb begin
    acc   = '0;
    valid = '0;
    idx   = '0;
    own   = '0;
    wmask = '0;
    for (int p = 0; p < 2; p++) begin
      valid[p] = (addr[p] >> (ADDR_WIDTH + 2)) == 32'd0;
      idx[p]   = addr[p][ADDR_WIDTH+1:2];
      acc[p]   = rst_n && (state_q == S_READY) && en[p];
      own[p]   = valid[p] ? we[p] : '0;
    end
    same     = acc[0] && acc[1] && valid[0] && valid[1] && (idx[0] == idx[1]);
    coll_now = same && (|own[0]) && (|own[1]);
    // A owns every lane it writes; B only lands in the lanes A leaves alone.
    wmask[0] = acc[0] ? own[0] : '0;
    wmask[1] = acc[1] ? (own[1] & ~({LANES{same}} & own[0])) : '0;
  end

  // Array and raw read registers carry no reset so the array maps onto block RAM.
  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [1:0][DATA_WIDTH-1:0] raw_q;

  always_ff @(posedge clk) begin
    if (rst_n && init_busy) mem[clr_ptr] <= '0;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) raw_q[p] <= mem[idx[p]];
      for (int l = 0; l < LANES; l++)
        if (wmask[p][l]) mem[idx[p]][8*l +: 8] <= din[p][8*l +: 8];
    end
  end

  // Side-band captured with each read; together with raw_q it rebuilds the word and holds it.
  logic [1:0]                  vld1, inv1, zero1, err_q;
  logic [1:0][LANES-1:0]       mm1;
  logic [1:0][DATA_WIDTH-1:0]  din1, d1, d2;
  logic [1:0]                  v2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1  <= '0;
      inv1  <= '0;
      zero1 <= '1;
      err_q <= '0;
      mm1   <= '0;
      din1  <= '0;
    end else begin
      vld1  <= acc;
      err_q <= acc & ~valid;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          zero1[p] <= 1'b0;
          inv1[p]  <= ~valid[p];
          mm1[p]   <= (WRITE_FIRST != 0) ? own[p] : '0;
          din1[p]  <= din[p];
        end
      end
    end
  end

  always_comb begin
    d1 = raw_q;
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < LANES; l++)
        if (mm1[p][l]) d1[p][8*l +: 8] = din1[p][8*l +: 8];
      if (zero1[p] || inv1[p]) d1[p] = '0;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d2 <= '0;
        v2 <= '0;
      end else begin
        v2 <= vld1;
        for (int p = 0; p < 2; p++)
          if (vld1[p]) d2[p] <= d1[p];
      end
    end
  end else begin : g_noreg
    assign d2 = d1;
    assign v2 = vld1;
  end

  assign douta      = d2[0];
  assign doutb      = d2[1];
  assign douta_vld  = v2[0];
  assign doutb_vld  = v2[1];
  assign addr_err_a = err_q[0];
  assign addr_err_b = err_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision <= 1'b0;
      coll_cnt  <= '0;
    end else begin
      collision <= coll_now;
      if (coll_now && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end

endmodule
